// File: rtl/change_dispense_ctrl_pkg.sv
// ============================================================================
// change_dispense_ctrl_pkg : coin denominations and FSM states for change return
// Revision: 1.0
// ============================================================================
`default_nettype none

package change_dispense_ctrl_pkg;

  localparam int C_NUM_COINS = 3;

  // Denomination 0 is the smallest coin.
  localparam int unsigned C_COIN_VALUE [C_NUM_COINS] = '{32'd100, 32'd500, 32'd1000};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic int unsigned coin_value(input logic [C_NUM_COINS-1:0] sel);
    int unsigned v;
    v = 0;
    for (int d = 0; d < C_NUM_COINS; d++) begin
      if (sel[d]) v = v | C_COIN_VALUE[d];
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/change_dispense_ctrl_greedy_coin_pick.sv
// ============================================================================
// greedy_coin_pick : largest in-stock denomination not exceeding the amount owed
// Revision: 1.0
// ============================================================================
`default_nettype none

module greedy_coin_pick
  import change_dispense_ctrl_pkg::*;
#(
  parameter int AMT_W   = 32,
  parameter int STOCK_W = 8
) (
  input  logic [AMT_W-1:0]             i_remaining,
  input  logic [C_NUM_COINS*STOCK_W-1:0] i_stock,
  output logic                         o_found,
  output logic [C_NUM_COINS-1:0]       o_sel
);

  always_comb begin
    o_found = 1'b0;
    o_sel   = '0;
    for (int d = C_NUM_COINS - 1; d >= 0; d--) begin
      if (!o_found && (i_stock[d*STOCK_W +: STOCK_W] != '0) &&
          (AMT_W'(C_COIN_VALUE[d]) <= i_remaining)) begin
        o_found  = 1'b1;
        o_sel[d] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/change_dispense_ctrl.sv
// ============================================================================
// change_dispense_ctrl : greedy coin-return sequencer with per-denomination stock
// Revision: 1.0
// ============================================================================
`default_nettype none

module change_dispense_ctrl
  import change_dispense_ctrl_pkg::*;
#(
  parameter int AMT_W      = 32,
  parameter int STOCK_W    = 8,
  parameter int STOCK_INIT = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_start,
  input  logic [AMT_W-1:0]               i_amount,
  input  logic [C_NUM_COINS-1:0]         i_refill,
  input  logic                           i_coin_ready,
  output logic                           o_coin_valid,
  output logic [C_NUM_COINS-1:0]         o_coin_sel,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_short,
  output logic [AMT_W-1:0]               o_remaining,
  output logic [C_NUM_COINS*STOCK_W-1:0] o_stock
);

  state_e                         r_state;
  state_e                         w_state_next;
  logic [AMT_W-1:0]               r_remaining;
  logic                           r_coin_valid;
  logic [C_NUM_COINS-1:0]         r_coin_sel;
  logic                           r_short;
  logic [C_NUM_COINS*STOCK_W-1:0] w_stock;
  logic                           w_found;
  logic [C_NUM_COINS-1:0]         w_pick_sel;
  logic                           w_handshake;
  logic [C_NUM_COINS-1:0]         w_dispense;
  logic [AMT_W-1:0]               w_coin_amt;

  greedy_coin_pick #(
    .AMT_W   (AMT_W),
    .STOCK_W (STOCK_W)
  ) u_pick (
    .i_remaining (r_remaining),
    .i_stock     (w_stock),
    .o_found     (w_found),
    .o_sel       (w_pick_sel)
  );

  assign w_handshake = (r_state == ST_ISSUE) && i_coin_ready;
  assign w_dispense  = w_handshake ? r_coin_sel : '0;
  assign w_coin_amt  = AMT_W'(coin_value(r_coin_sel));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_state_next = ST_SELECT;
      ST_SELECT: w_state_next = w_found ? ST_ISSUE : ST_DONE;
      ST_ISSUE:  if (i_coin_ready) w_state_next = ST_SELECT;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_remaining  <= '0;
      r_coin_valid <= 1'b0;
      r_coin_sel   <= '0;
      r_short      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_remaining <= i_amount;
            r_short     <= 1'b0;
          end
        end
        ST_SELECT: begin
          if (w_found) begin
            r_coin_sel   <= w_pick_sel;
            r_coin_valid <= 1'b1;
          end else begin
            r_short <= (r_remaining != '0);
          end
        end
        ST_ISSUE: begin
          // Selection guaranteed the coin value fits, so this cannot underflow.
          if (i_coin_ready) begin
            r_remaining  <= r_remaining - w_coin_amt;
            r_coin_valid <= 1'b0;
            r_coin_sel   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < C_NUM_COINS; g++) begin : g_stock
    logic [STOCK_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt <= STOCK_W'(STOCK_INIT);
      end else if (i_refill[g] && !w_dispense[g]) begin
        if (r_cnt != '1) r_cnt <= r_cnt + STOCK_W'(1);
      end else if (!i_refill[g] && w_dispense[g]) begin
        r_cnt <= r_cnt - STOCK_W'(1);
      end
    end
    assign w_stock[g*STOCK_W +: STOCK_W] = r_cnt;
  end

  assign o_coin_valid = r_coin_valid;
  assign o_coin_sel   = r_coin_sel;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = (r_state == ST_DONE);
  assign o_short      = r_short;
  assign o_remaining  = r_remaining;
  assign o_stock      = w_stock;

endmodule

`default_nettype wire

// File: tb/tb_change_dispense_ctrl.sv
// ============================================================================
// tb_change_dispense_ctrl : directed and random checks against a behavioural model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_change_dispense_ctrl;

  localparam int NC = 3;
  localparam int VAL [NC] = '{100, 500, 1000};
  localparam int P_IDLE = 0, P_PICK = 1, P_WAIT = 2, P_END = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_start = 1'b0;
  logic [31:0]   i_amount = '0;
  logic [NC-1:0] i_refill = '0;
  logic          i_coin_ready = 1'b0;
  logic          o_coin_valid;
  logic [NC-1:0] o_coin_sel;
  logic          o_busy;
  logic          o_done;
  logic          o_short;
  logic [31:0]   o_remaining;
  logic [23:0]   o_stock;

  change_dispense_ctrl #(
    .AMT_W      (32),
    .STOCK_W    (8),
    .STOCK_INIT (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_amount     (i_amount),
    .i_refill     (i_refill),
    .i_coin_ready (i_coin_ready),
    .o_coin_valid (o_coin_valid),
    .o_coin_sel   (o_coin_sel),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_short      (o_short),
    .o_remaining  (o_remaining),
    .o_stock      (o_stock)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: amount owed, coins in the tube, and where the return is.
  int m_phase, m_rem, m_short, m_valid, m_sel;
  int m_stock [NC];
  bit m_init = 1'b0;

  function automatic int greedy(input int rem);
    for (int d = NC - 1; d >= 0; d--)
      if (m_stock[d] > 0 && VAL[d] <= rem) return d;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int d;
    int disp;
    if (reset) begin
      m_phase = P_IDLE; m_rem = 0; m_short = 0; m_valid = 0; m_sel = 0;
      for (int k = 0; k < NC; k++) m_stock[k] = 8;
      m_init = 1'b1;
    end else if (m_init) begin
      disp = 0;
      case (m_phase)
        P_IDLE: if (i_start) begin m_rem = int'(i_amount); m_short = 0; m_phase = P_PICK; end
        P_PICK: begin
          d = greedy(m_rem);
          if (d >= 0) begin m_sel = 1 << d; m_valid = 1; m_phase = P_WAIT; end
          else begin m_short = (m_rem != 0); m_phase = P_END; end
        end
        P_WAIT: if (i_coin_ready) begin
          for (int k = 0; k < NC; k++) if (m_sel == (1 << k)) m_rem = m_rem - VAL[k];
          disp = m_sel; m_valid = 0; m_sel = 0; m_phase = P_PICK;
        end
        default: m_phase = P_IDLE;
      endcase
      for (int k = 0; k < NC; k++) begin
        if (i_refill[k] && !disp[k]) m_stock[k] = (m_stock[k] < 255) ? m_stock[k] + 1 : 255;
        else if (!i_refill[k] && disp[k]) m_stock[k] = m_stock[k] - 1;
      end
    end
  end

  logic [NC-1:0] hs_log [$];

  always @(negedge clk) begin
    if (m_init) begin
      check("valid", o_coin_valid, m_valid);
      check("sel", o_coin_sel, m_sel);
      check("busy", o_busy, m_phase != P_IDLE);
      check("done", o_done, m_phase == P_END);
      check("short", o_short, m_short);
      check("remaining", o_remaining, m_rem);
      check("stock", o_stock, (longint'(m_stock[2]) << 16) | (longint'(m_stock[1]) << 8) | longint'(m_stock[0]));
    end
    if (!reset && o_coin_valid && i_coin_ready) hs_log.push_back(o_coin_sel);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic start(input int amt);
    int k;
    for (k = 0; k < 50 && o_busy; k++) tick();
    check("start_idle", o_busy, 0);
    i_start = 1'b1; i_amount = amt; tick(); i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      tick();
      if (o_done) break;
    end
    check({name, "_done_seen"}, k < budget, 1);
  endtask

  initial begin
    logic [NC-1:0] e1 [3];
    e1 = '{3'b100, 3'b010, 3'b001};

    reset = 1'b1; repeat (3) @(posedge clk); #1; reset = 1'b0;
    check("rst_valid", o_coin_valid, 0);
    check("rst_sel", o_coin_sel, 0);
    check("rst_short", o_short, 0);
    check("rst_rem", o_remaining, 0);
    check("rst_stock", o_stock, 24'h080808);

    // 1600 with full stock: 1000, 500, 100.
    i_coin_ready = 1'b1; hs_log.delete();
    start(1600); wait_done(30, "t1");
    check("t1_ncoins", hs_log.size(), 3);
    for (int i = 0; i < 3; i++) check("t1_coin", (i < hs_log.size()) ? hs_log[i] : 0, e1[i]);
    check("t1_rem", o_remaining, 0);
    check("t1_short", o_short, 0);
    check("t1_stock", o_stock, 24'h070707);

    // Backpressure: request held stable, single decrement on acceptance.
    do_reset(); i_coin_ready = 1'b0; hs_log.delete();
    start(1000); tick();
    for (int i = 0; i < 3; i++) begin
      check("t2_valid_held", o_coin_valid, 1);
      check("t2_sel_held", o_coin_sel, 3'b100);
      check("t2_stock_held", o_stock[23:16], 8);
      tick();
    end
    i_coin_ready = 1'b1; tick();
    check("t2_stock_dec", o_stock[23:16], 7);
    check("t2_valid_drop", o_coin_valid, 0);
    wait_done(10, "t2");
    check("t2_ncoins", hs_log.size(), 1);

    // Out of 1000s: 2000 paid as four 500s.
    do_reset(); i_coin_ready = 1'b1;
    start(8000); wait_done(40, "t3a");
    check("t3_empty1000", o_stock[23:16], 0);
    hs_log.delete();
    start(2000); wait_done(40, "t3b");
    check("t3_ncoins", hs_log.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_coin", (i < hs_log.size()) ? hs_log[i] : 0, 3'b010);
    check("t3_stock500", o_stock[15:8], 4);
    check("t3_short", o_short, 0);

    // Residue below smallest coin.
    do_reset(); hs_log.delete();
    start(150); wait_done(20, "t4");
    check("t4_short", o_short, 1);
    check("t4_rem", o_remaining, 50);
    check("t4_ncoins", hs_log.size(), 1);
    check("t4_coin", (hs_log.size() > 0) ? hs_log[0] : 0, 3'b001);

    // Refill colliding with a dispense of the same denomination, then saturation.
    do_reset(); i_coin_ready = 1'b0;
    start(100); tick();
    i_coin_ready = 1'b1; i_refill = 3'b001; tick(); i_refill = '0;
    check("t5_net0", o_stock[7:0], 8);
    wait_done(10, "t5");
    i_refill = 3'b011;
    repeat (260) tick();
    i_refill = '0;
    check("t5_sat100", o_stock[7:0], 255);
    check("t5_sat500", o_stock[15:8], 255);
    check("t5_keep1000", o_stock[23:16], 8);

    // Reset mid-issue, then a start while busy is ignored.
    do_reset(); i_coin_ready = 1'b0;
    start(1000); tick();
    check("t6_in_issue", o_coin_valid, 1);
    do_reset();
    check("t6_valid", o_coin_valid, 0);
    check("t6_busy", o_busy, 0);
    check("t6_stock", o_stock, 24'h080808);
    hs_log.delete();
    start(1000); tick();
    i_start = 1'b1; i_amount = 500; tick(); i_start = 1'b0;
    check("t6_ignored", o_remaining, 1000);
    i_coin_ready = 1'b1;
    wait_done(10, "t6");
    check("t6_ncoins", hs_log.size(), 1);
    check("t6_rem", o_remaining, 0);

    // Random traffic; the model compare covers every cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      i_start      = ($urandom_range(0, 5) == 0);
      i_amount     = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 60) * 50 : $urandom_range(0, 3000);
      i_coin_ready = ($urandom_range(0, 3) != 0);
      i_refill     = ($urandom_range(0, 7) == 0) ? NC'($urandom_range(0, 7)) : '0;
      reset        = ($urandom_range(0, 499) == 0);
      tick();
    end
    i_start = 1'b0; i_refill = '0; reset = 1'b0; i_coin_ready = 1'b1;
    repeat (30) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
